// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants and encodings for the CPU-to-memory bus controller.
package mem_bus_ctrl_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int WRITE_WAIT   = 2;
  localparam int READ_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    R_REL = 3'd2,
    WRITE = 3'd3,
    W_REL = 3'd4
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bundle: instruction fetch port and data port.
interface mem_bus_ctrl_if
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) ();

  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic             i_accept;
  logic             i_rsp_valid;
  logic [WIDTH-1:0] i_rdata;

  logic             d_req;
  logic             d_write;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_accept;
  logic             d_rsp_valid;
  logic [WIDTH-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata,
    input  i_accept, i_rsp_valid, i_rdata, d_accept, d_rsp_valid, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata,
    output i_accept, i_rsp_valid, i_rdata, d_accept, d_rsp_valid, d_rdata
  );

endinterface

// File: rtl/mem_bus_ctrl_arbiter.sv
// Fixed-priority pick between the data and fetch ports; data always wins.
module mem_port_arbiter
  import mem_bus_ctrl_pkg::*;
(
  input  logic   iReq,
  input  logic   dReq,
  input  logic   dWrite,
  output logic   grant,
  output owner_t owner,
  output logic   isWrite
);

  always_comb begin
    grant   = iReq | dReq;
    owner   = dReq ? OWNER_D : OWNER_I;
    isWrite = dReq & dWrite;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus controller: arbitrates fetch/data requests onto the single memory bus.
// state | meaning
// IDLE  | bus released, accepting requests
// READ  | readM high, waiting for inputReady or timeout
// R_REL | readM low, read response pulse to owner
// WRITE | writeM high, data driven for WRITE_WAIT cycles
// W_REL | writeM low, data held, write response pulse
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int W            = WORD_SIZE,
  parameter int WRITE_CYCLES = WRITE_WAIT,
  parameter int READ_LIMIT   = READ_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_bus_ctrl_if.slave   cpu,
  output logic            readM,
  output logic            writeM,
  output logic [W-1:0]    address,
  inout  wire  [W-1:0]    data,
  input  logic            inputReady,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CNT_MAX = (READ_LIMIT > WRITE_CYCLES) ? READ_LIMIT : WRITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t         state;
  owner_t         owner;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   wdata;
  logic           dataOe;

  logic           grant;
  owner_t         grantOwner;
  logic           grantWrite;
  logic [W-1:0]   readWord;

  mem_port_arbiter u_arb (
    .iReq   (cpu.i_req),
    .dReq   (cpu.d_req),
    .dWrite (cpu.d_write),
    .grant  (grant),
    .owner  (grantOwner),
    .isWrite(grantWrite)
  );

  assign data     = dataOe ? wdata : {W{1'bz}};
  assign busy     = (state != IDLE);
  // A timed-out read returns all ones so software can spot it.
  assign readWord = inputReady ? data : {W{1'b1}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      owner           <= OWNER_I;
      cnt             <= '0;
      wdata           <= '0;
      dataOe          <= 1'b0;
      readM           <= 1'b0;
      writeM          <= 1'b0;
      address         <= '0;
      timeout_err     <= 1'b0;
      cpu.i_accept    <= 1'b0;
      cpu.i_rsp_valid <= 1'b0;
      cpu.i_rdata     <= '0;
      cpu.d_accept    <= 1'b0;
      cpu.d_rsp_valid <= 1'b0;
      cpu.d_rdata     <= '0;
    end else begin
      cpu.i_accept    <= 1'b0;
      cpu.d_accept    <= 1'b0;
      cpu.i_rsp_valid <= 1'b0;
      cpu.d_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= grantOwner;
            if (grantOwner == OWNER_D) begin
              cpu.d_accept <= 1'b1;
              address      <= cpu.d_addr;
              wdata        <= cpu.d_wdata;
            end else begin
              cpu.i_accept <= 1'b1;
              address      <= cpu.i_addr;
            end
            if (grantWrite) begin
              cnt    <= CNT_W'(WRITE_CYCLES - 1);
              writeM <= 1'b1;
              dataOe <= 1'b1;
              state  <= WRITE;
            end else begin
              cnt   <= CNT_W'(READ_LIMIT - 1);
              readM <= 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          if (inputReady || (cnt == '0)) begin
            if (!inputReady) timeout_err <= 1'b1;
            if (owner == OWNER_D) begin
              cpu.d_rdata     <= readWord;
              cpu.d_rsp_valid <= 1'b1;
            end else begin
              cpu.i_rdata     <= readWord;
              cpu.i_rsp_valid <= 1'b1;
            end
            readM <= 1'b0;
            state <= R_REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_REL: state <= IDLE;
        WRITE: begin
          if (cnt == '0) begin
            writeM          <= 1'b0;
            cpu.d_rsp_valid <= 1'b1;
            state           <= W_REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_REL: begin
          dataOe <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
